// File: rtl/product_accumulator.sv
// Product accumulator: sums groups of multiplier products closed by in_last
// and hands the total, count and sticky overflow out over valid/ready.
module product_accumulator #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M+N-1:0]   product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam int P = M + N;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;

  logic               accept;
  logic               drain;
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_nxt;

  assign accept  = in_valid && in_ready;
  assign drain   = (state_q == DONE) && out_ready;
  // Carry out of the widened add feeds the sticky overflow flag.
  assign sum_ext = {1'b0, acc_q}
                 + {{(ACC_W + 1 - P){1'b0}}, product};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign ovf_nxt = ovf_q | sum_ext[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:  if (accept && in_last) state_d = DONE;
      DONE: if (out_ready)         state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Handshake outputs depend on state only; reset masks in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACC:  in_ready  = rst_n;
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    sum_d  = sum_q;
    ocnt_d = ocnt_q;
    oovf_d = oovf_q;
    if (accept) begin
      acc_d = sum_ext[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_nxt;
      if (in_last) begin
        sum_d  = sum_ext[ACC_W-1:0];
        ocnt_d = cnt_inc;
        oovf_d = ovf_nxt;
      end
    end
    if (drain) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      sum_q  <= '0;
      ocnt_q <= '0;
      oovf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      sum_q  <= sum_d;
      ocnt_q <= ocnt_d;
      oovf_q <= oovf_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_count    = ocnt_q;
  assign out_overflow = oovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed vector bench for product_accumulator with default parameters.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_overflow;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .product      (product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  // {in_ready, out_valid, out_sum, out_count, out_overflow}
  typedef logic [26:0] obs_t;

  typedef struct {
    logic       v;
    logic [7:0] p;
    logic       l;
    logic       ordy;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t ob(logic r, logic ov, int s, int c, logic f);
    obs_t o;
    o = {r, ov, 16'(s), 8'(c), f};
    return o;
  endfunction

  function automatic vec_t mk(logic v, int p, logic l, logic ordy, obs_t e);
    vec_t x;
    x.v    = v;
    x.p    = 8'(p);
    x.l    = l;
    x.ordy = ordy;
    x.exp  = e;
    return x;
  endfunction

  function automatic obs_t now_obs();
    return {in_ready, out_valid, out_sum, out_count, out_overflow};
  endfunction

  task automatic chk(string name, obs_t act, obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, want rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b",
               name, act[26], act[25], act[24:9], act[8:1], act[0],
               exp[26], exp[25], exp[24:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic drive(logic v, int p, logic l, logic ordy);
    in_valid  = v;
    product   = 8'(p);
    in_last   = l;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);

    // basic group: 3 x 225
    vecs.push_back(mk(1, 225, 0, 0, ob(1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 225, 0, 0, ob(1, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 225, 1, 0, ob(1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, ob(0, 1, 675, 3, 0)));
    // single product 63, out_ready ignored in ACC
    vecs.push_back(mk(1, 63, 1, 1, ob(1, 0, 675, 3, 0)));
    // backpressure with junk input
    vecs.push_back(mk(1, 99, 1, 0, ob(0, 1, 63, 1, 0)));
    vecs.push_back(mk(1, 17, 0, 0, ob(0, 1, 63, 1, 0)));
    vecs.push_back(mk(1, 250, 1, 0, ob(0, 1, 63, 1, 0)));
    vecs.push_back(mk(1, 1, 0, 0, ob(0, 1, 63, 1, 0)));
    vecs.push_back(mk(1, 128, 1, 0, ob(0, 1, 63, 1, 0)));
    vecs.push_back(mk(1, 77, 1, 1, ob(0, 1, 63, 1, 0)));
    // group 2 + 3
    vecs.push_back(mk(1, 2, 0, 0, ob(1, 0, 63, 1, 0)));
    vecs.push_back(mk(1, 3, 1, 0, ob(1, 0, 63, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 1, ob(0, 1, 5, 2, 0)));
    // input gaps with in_last in the gaps
    vecs.push_back(mk(1, 10, 0, 1, ob(1, 0, 5, 2, 0)));
    vecs.push_back(mk(0, 44, 1, 0, ob(1, 0, 5, 2, 0)));
    vecs.push_back(mk(1, 20, 0, 0, ob(1, 0, 5, 2, 0)));
    vecs.push_back(mk(0, 55, 1, 0, ob(1, 0, 5, 2, 0)));
    vecs.push_back(mk(1, 30, 1, 0, ob(1, 0, 5, 2, 0)));
    vecs.push_back(mk(0, 0, 0, 0, ob(0, 1, 60, 3, 0)));
    vecs.push_back(mk(0, 0, 0, 1, ob(0, 1, 60, 3, 0)));
    vecs.push_back(mk(0, 0, 0, 0, ob(1, 0, 60, 3, 0)));

    repeat (2) @(negedge clk);
    #1 chk("reset_state", now_obs(), ob(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1 chk("post_reset", now_obs(), ob(1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, int'(vecs[i].p), vecs[i].l, vecs[i].ordy);
      #1 chk($sformatf("vec%0d", i), now_obs(), vecs[i].exp);
    end

    // overflow and count saturation: 292 x 225 = 65700
    for (int i = 0; i < 292; i++) begin
      @(negedge clk);
      drive(1, 225, i == 291, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1 chk("overflow", now_obs(), ob(0, 1, 164, 255, 1));
    @(negedge clk);
    drive(0, 0, 0, 1);
    #1 chk("ovf_hold", now_obs(), ob(0, 1, 164, 255, 1));
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1 chk("ovf_drained", now_obs(), ob(1, 0, 164, 255, 1));

    // reset mid-group discards 100 + 200
    @(negedge clk);
    drive(1, 100, 0, 0);
    @(negedge clk);
    drive(1, 200, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1 chk("mid_reset", now_obs(), ob(0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    #1 chk("mid_release", now_obs(), ob(1, 0, 0, 0, 0));
    @(negedge clk);
    drive(1, 7, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1 chk("after_reset", now_obs(), ob(0, 1, 7, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
